cache_fill_fsm: RTL and testbench

Miss handler that sequences refill of the direct-mapped cache (128 blocks x 8 words, 16-bit words, tag in address[15:11]). On a miss it issues eight pipelined word reads to main memory, writes each returned word into the data array, then writes the tag into the metadata array. It sits between the cache pipeline (miss_detected/stall) and the multi-cycle main memory. One instance per cache (I-cache, D-cache); the memory arbiter is outside this block.

---
 rtl/cache_fill_fsm.sv | 106 ++++++++++
 tb/tb_cache_fill_fsm.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
// Refill sequencer for a direct-mapped cache: one block of pipelined word reads per miss,
// each returned word written to the data array, tag written together with the final word.
module cache_fill_fsm #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_WIDTH      = 16,
  parameter int DATA_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_detected,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  input  logic                  memory_data_valid,
  input  logic [DATA_WIDTH-1:0] memory_data,
  output logic                  fsm_busy,
  output logic                  mem_read,
  output logic [ADDR_WIDTH-1:0] memory_address,
  output logic [ADDR_WIDTH-1:0] cache_address,
  output logic [DATA_WIDTH-1:0] cache_data,
  output logic                  write_data_array,
  output logic                  write_tag_array
);

  localparam int CW          = $clog2(WORDS_PER_BLOCK) + 1;
  localparam int WORD_BYTES  = DATA_WIDTH / 8;
  localparam int BLOCK_BYTES = WORDS_PER_BLOCK * WORD_BYTES;
  localparam logic [ADDR_WIDTH-1:0] BLOCK_MASK = ~ADDR_WIDTH'(BLOCK_BYTES - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WORDS_PER_BLOCK);
  localparam logic [CW-1:0] CNT_LAST = CW'(WORDS_PER_BLOCK - 1);

  typedef enum logic {
    S_IDLE,
    S_FILL
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [CW-1:0]         r_req_cnt;
  logic [CW-1:0]         r_rsp_cnt;
  logic                  w_issue;
  logic                  w_accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_base    <= '0;
      r_req_cnt <= '0;
      r_rsp_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (miss_detected) begin
            r_base    <= miss_address & BLOCK_MASK;
            r_req_cnt <= '0;
            r_rsp_cnt <= '0;
          end
        end
        S_FILL: begin
          if (w_issue)  r_req_cnt <= r_req_cnt + CW'(1);
          if (w_accept) r_rsp_cnt <= r_rsp_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Request and response streams run independently; responses may overlap issuing.
  always_comb begin
    w_next_state     = r_state;
    w_issue          = 1'b0;
    w_accept         = 1'b0;
    fsm_busy         = 1'b0;
    mem_read         = 1'b0;
    memory_address   = '0;
    cache_address    = '0;
    cache_data       = '0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (miss_detected) w_next_state = S_FILL;
      end
      S_FILL: begin
        fsm_busy = 1'b1;
        if (r_req_cnt < CNT_FULL) begin
          w_issue        = 1'b1;
          mem_read       = 1'b1;
          memory_address = r_base + ADDR_WIDTH'(int'(r_req_cnt) * WORD_BYTES);
        end
        if (memory_data_valid && (r_rsp_cnt < CNT_FULL)) begin
          w_accept         = 1'b1;
          write_data_array = 1'b1;
          cache_address    = r_base + ADDR_WIDTH'(int'(r_rsp_cnt) * WORD_BYTES);
          cache_data       = memory_data;
          if (r_rsp_cnt == CNT_LAST) begin
            write_tag_array = 1'b1;
            w_next_state    = S_IDLE;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: queue-based reference of the expected request/write streams
// against a 4-cycle pipelined memory with optional bubbles and spurious inputs.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic        memory_data_valid = 1'b0;
  logic [15:0] memory_data = '0;
  logic        fsm_busy, mem_read, write_data_array, write_tag_array;
  logic [15:0] memory_address, cache_address, cache_data;

  cache_fill_fsm #(.WORDS_PER_BLOCK(8), .ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
    .memory_data_valid(memory_data_valid), .memory_data(memory_data),
    .fsm_busy(fsm_busy), .mem_read(mem_read), .memory_address(memory_address),
    .cache_address(cache_address), .cache_data(cache_data),
    .write_data_array(write_data_array), .write_tag_array(write_tag_array)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;

  // reference: a fill is a list of pending request addresses and pending write addresses
  logic        m_fill = 1'b0;
  logic [15:0] req_q[$];
  logic [15:0] wr_q[$];

  // memory: in-order responses, each due 4 cycles after its request
  int unsigned mq_due[$];
  logic [15:0] mq_data[$];
  logic [15:0] data_base = 16'hA000;
  int          gap_pct = 0;
  int          gap_left = 0;
  int          bubble_at = -1;
  int          bubble_len = 0;
  int          delivered = 0;
  bit          spur_idle = 0;
  bit          spur_miss = 0;

  int unsigned busy_cnt, tag_cnt, wr_cnt;
  logic [15:0] tag_addr;
  logic [15:0] wr_data_q[$];

  task automatic clear_stats();
    busy_cnt = 0; tag_cnt = 0; wr_cnt = 0; tag_addr = '0; delivered = 0;
    wr_data_q.delete();
  endtask

  task automatic step(input logic s_rst, input logic s_miss, input logic [15:0] s_addr);
    logic        e_rd, e_wr, e_tag;
    logic [15:0] e_maddr, e_caddr, e_cdata, base;
    logic [51:0] exp_v, act_v;
    @(negedge clk);
    rst = s_rst; miss_detected = s_miss; miss_address = s_addr;
    memory_data_valid = 1'b0; memory_data = '0;
    if (gap_left > 0) begin
      gap_left--;
    end else if (mq_due.size() > 0 && mq_due[0] <= cyc && $urandom_range(0, 99) >= gap_pct) begin
      memory_data_valid = 1'b1;
      memory_data = mq_data.pop_front();
      void'(mq_due.pop_front());
      delivered++;
      if (delivered == bubble_at) gap_left = bubble_len;
    end else if (spur_idle && !m_fill && mq_due.size() == 0 && $urandom_range(0, 1) == 1) begin
      memory_data_valid = 1'b1;
      memory_data = 16'($urandom);
    end
    #1;
    e_rd    = m_fill && req_q.size() > 0;
    e_maddr = e_rd ? req_q[0] : 16'h0;
    e_wr    = m_fill && memory_data_valid && wr_q.size() > 0;
    e_caddr = e_wr ? wr_q[0] : 16'h0;
    e_cdata = e_wr ? memory_data : 16'h0;
    e_tag   = e_wr && wr_q.size() == 1;
    exp_v = {m_fill, e_rd, e_maddr, e_caddr, e_cdata, e_wr, e_tag};
    act_v = {fsm_busy, mem_read, memory_address, cache_address, cache_data,
             write_data_array, write_tag_array};
    vectors++;
    if (act_v !== exp_v) begin
      miscompares++;
      $display("FAIL cycle_outputs cyc=%0d {busy,rd,maddr,caddr,cdata,wd,wt} got %b/%b/%h/%h/%h/%b/%b want %b/%b/%h/%h/%h/%b/%b",
               cyc, act_v[51], act_v[50], act_v[49:34], act_v[33:18], act_v[17:2], act_v[1], act_v[0],
               exp_v[51], exp_v[50], exp_v[49:34], exp_v[33:18], exp_v[17:2], exp_v[1], exp_v[0]);
    end
    if (mem_read === 1'b1) begin
      mq_due.push_back(cyc + 4);
      mq_data.push_back(data_base + 16'(memory_address[3:1]));
    end
    if (fsm_busy === 1'b1) busy_cnt++;
    if (write_data_array === 1'b1) begin wr_cnt++; wr_data_q.push_back(cache_data); end
    if (write_tag_array === 1'b1) begin tag_cnt++; tag_addr = cache_address; end
    if (s_rst) begin
      m_fill = 1'b0; req_q.delete(); wr_q.delete();
    end else if (!m_fill) begin
      if (s_miss) begin
        m_fill = 1'b1;
        base = {s_addr[15:4], 4'h0};
        for (int i = 0; i < 8; i++) begin
          req_q.push_back(base + 16'(2 * i));
          wr_q.push_back(base + 16'(2 * i));
        end
      end
    end else begin
      if (e_rd) void'(req_q.pop_front());
      if (e_wr) void'(wr_q.pop_front());
      if (e_tag) m_fill = 1'b0;
    end
    cyc++;
  endtask

  task automatic run_fill(input logic [15:0] addr);
    step(1'b0, 1'b1, addr);
    for (int i = 0; i < 60 && m_fill; i++)
      step(1'b0, spur_miss ? 1'($urandom_range(0, 1)) : 1'b0, 16'($urandom));
    vectors++;
    if (m_fill) begin
      miscompares++;
      $display("FAIL fill_timeout addr=%h still busy after 60 cycles, want done", addr);
    end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 16'h1234);
    step(1'b1, 1'b1, 16'h1234);
    clear_stats();
    data_base = 16'h5500;
    run_fill(16'h1234);
    vectors++;
    if (wr_cnt != 8 || tag_cnt != 1) begin
      miscompares++;
      $display("FAIL reset_then_fill writes=%0d tags=%0d want 8/1", wr_cnt, tag_cnt);
    end
  endtask

  task automatic test_single_fill();
    step(1'b0, 1'b0, 16'h0);
    clear_stats();
    data_base = 16'hA000;
    run_fill(16'h1A36);
    vectors++;
    if (busy_cnt != 12) begin
      miscompares++;
      $display("FAIL single_busy got %0d cycles want 12", busy_cnt);
    end
    vectors++;
    if (tag_cnt != 1 || tag_addr[15:11] !== 5'h03) begin
      miscompares++;
      $display("FAIL single_tag got count %0d tag %h want 1/03", tag_cnt, tag_addr[15:11]);
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (i >= wr_data_q.size() || wr_data_q[i] !== 16'hA000 + 16'(i)) begin
        miscompares++;
        $display("FAIL single_data word %0d got %h want %h", i,
                 (i < wr_data_q.size()) ? wr_data_q[i] : 16'hxxxx, 16'hA000 + 16'(i));
      end
    end
  endtask

  task automatic test_bubbled_memory();
    step(1'b0, 1'b0, 16'h0);
    clear_stats();
    bubble_at = 3; bubble_len = 3;
    data_base = 16'h3C00;
    run_fill(16'h4C8A);
    bubble_at = -1;
    vectors++;
    if (busy_cnt != 15 || wr_cnt != 8 || tag_cnt != 1) begin
      miscompares++;
      $display("FAIL bubble_fill busy/writes/tags got %0d/%0d/%0d want 15/8/1", busy_cnt, wr_cnt, tag_cnt);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b0, 1'b0, 16'h0);
    data_base = 16'h0B00;
    run_fill(16'h0010);
    clear_stats();
    data_base = 16'hF000;
    run_fill(16'hFFF2);
    vectors++;
    if (busy_cnt != 12 || tag_addr !== 16'hFFFE) begin
      miscompares++;
      $display("FAIL back_to_back busy=%0d tag_addr=%h want 12/fffe", busy_cnt, tag_addr);
    end
  endtask

  task automatic test_reset_mid_fill();
    step(1'b0, 1'b0, 16'h0);
    clear_stats();
    data_base = 16'h7700;
    step(1'b0, 1'b1, 16'h2468);
    for (int i = 0; i < 40 && wr_cnt < 4; i++) step(1'b0, 1'b0, 16'h0);
    vectors++;
    if (wr_cnt != 4) begin
      miscompares++;
      $display("FAIL mid_reset_setup writes=%0d want 4", wr_cnt);
    end
    step(1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 16'h0);
    vectors++;
    if (tag_cnt != 0) begin
      miscompares++;
      $display("FAIL mid_reset_tag got %0d tag writes want 0", tag_cnt);
    end
    clear_stats();
    run_fill(16'h2468);
    vectors++;
    if (wr_cnt != 8 || tag_cnt != 1) begin
      miscompares++;
      $display("FAIL mid_reset_refill writes=%0d tags=%0d want 8/1", wr_cnt, tag_cnt);
    end
  endtask

  task automatic test_random_spurious();
    logic [15:0] addr;
    gap_pct = 30; spur_idle = 1; spur_miss = 1;
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) step(1'b0, 1'b0, 16'($urandom));
      clear_stats();
      data_base = 16'($urandom);
      addr = 16'($urandom);
      run_fill(addr);
      vectors++;
      if (wr_cnt != 8 || tag_cnt != 1 || tag_addr[15:4] !== addr[15:4]) begin
        miscompares++;
        $display("FAIL random_fill addr=%h writes=%0d tags=%0d tag_addr=%h want 8/1/%h",
                 addr, wr_cnt, tag_cnt, tag_addr, {addr[15:4], 4'hE});
      end
    end
    gap_pct = 0; spur_idle = 0; spur_miss = 0;
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    test_reset();
    test_single_fill();
    test_bubbled_memory();
    test_back_to_back();
    test_reset_mid_fill();
    test_random_spurious();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
